// File: rtl/uart_csr_master_pkg.sv
// Shared types and constants for the UART-driven CSR bus initiator.
package uart_csr_master_pkg;

  localparam int unsigned TIMEOUT_W = 24;
  localparam int unsigned CSR_AW    = 14;
  localparam int unsigned CSR_DW    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NBYTES_W  = 3;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h02;
  localparam logic [BYTE_W-1:0] ACK_BYTE  = 8'h06;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    WDATA,
    WRITE,
    RADDR,
    RSAMPLE,
    TXSEND,
    TXWAIT
  } state_e;

  // Registered CSR bus request driven onto csr_a/csr_we/csr_do.
  typedef struct packed {
    logic [CSR_AW-1:0] addr;
    logic              we;
    logic [CSR_DW-1:0] wdata;
  } csr_req_t;

  function automatic logic is_cmd(input logic [BYTE_W-1:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/uart_csr_tx_serializer.sv
// Sends the top nbytes of a word, MSB first, one tx_wr per byte, each
// waiting for the transmitter's tx_done. done_c_o flags the final tx_done.
module uart_csr_tx_serializer
  import uart_csr_master_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [CSR_DW-1:0]   word_i,
  input  logic [NBYTES_W-1:0] nbytes_i,
  input  logic                tx_done_i,
  output logic [BYTE_W-1:0]   tx_data_o,
  output logic                tx_wr_o,
  output logic                done_c_o
);

  logic [CSR_DW-1:0]   shift_q, shift_d;
  logic [NBYTES_W-1:0] cnt_q, cnt_d;
  logic [NBYTES_W-1:0] nbytes_q, nbytes_d;
  logic                active_q, active_d;
  logic                tx_wr_q, tx_wr_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;

  // Serializer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      nbytes_q  <= '0;
      active_q  <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      nbytes_q  <= nbytes_d;
      active_q  <= active_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Load a word, or advance one byte on tx_done while waiting (not in the tx_wr cycle).
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    nbytes_d  = nbytes_q;
    active_d  = active_q;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    done_c_o  = 1'b0;
    if (load_i) begin
      shift_d   = word_i;
      cnt_d     = '0;
      nbytes_d  = nbytes_i;
      active_d  = 1'b1;
      tx_wr_d   = 1'b1;
      tx_data_d = word_i[CSR_DW-1 -: BYTE_W];
    end else if (active_q && !tx_wr_q && tx_done_i) begin
      shift_d = {shift_q[CSR_DW-BYTE_W-1:0], BYTE_W'(0)};
      cnt_d   = cnt_q + NBYTES_W'(1);
      if (cnt_d == nbytes_q) begin
        active_d = 1'b0;
        done_c_o = 1'b1;
      end else begin
        tx_wr_d   = 1'b1;
        tx_data_d = shift_d[CSR_DW-1 -: BYTE_W];
      end
    end
  end

  assign tx_data_o = tx_data_q;
  assign tx_wr_o   = tx_wr_q;

endmodule

// File: rtl/uart_csr_master.sv
// UART byte-stream to CSR bus initiator: decodes write (01 AH AL D3..D0)
// and read (02 AH AL) frames, drives the CSR bus and returns read data.
// Optional: UART_CSR_MASTER_WRACK_EN sends a 0x06 ACK byte after each write.
module uart_csr_master
  import uart_csr_master_pkg::*;
#(
  parameter int unsigned timeout_cycles = 1000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_done,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic              tx_done,
  output logic [CSR_AW-1:0] csr_a,
  output logic              csr_we,
  output logic [CSR_DW-1:0] csr_do,
  input  logic [CSR_DW-1:0] csr_di,
  output logic              busy
);

  localparam logic [TIMEOUT_W-1:0] TO_RELOAD = TIMEOUT_W'(timeout_cycles - 1);

  state_e                state_q, state_d;
  logic                  cmd_wr_q, cmd_wr_d;
  logic [CSR_AW-1:0]     addr_q, addr_d;
  logic [1:0]            wcnt_q, wcnt_d;
  logic [TIMEOUT_W-1:0]  to_q, to_d;
  csr_req_t              req_q, req_d;
  logic                  busy_q, busy_d;

  logic                  ser_load_c;
  logic [CSR_DW-1:0]     ser_word_c;
  logic [NBYTES_W-1:0]   ser_nbytes_c;
  logic                  ser_done_c;

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      cmd_wr_q <= 1'b0;
      addr_q   <= '0;
      wcnt_q   <= '0;
      to_q     <= '0;
      req_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_wr_q <= cmd_wr_d;
      addr_q   <= addr_d;
      wcnt_q   <= wcnt_d;
      to_q     <= to_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
    end
  end

  // Frame decode, inter-byte timeout and bus/serializer sequencing.
  always_comb begin
    state_d      = state_q;
    cmd_wr_d     = cmd_wr_q;
    addr_d       = addr_q;
    wcnt_d       = wcnt_q;
    to_d         = to_q;
    req_d        = req_q;
    ser_load_c   = 1'b0;
    ser_word_c   = '0;
    ser_nbytes_c = NBYTES_W'(4);

    unique case (state_q)
      IDLE: begin
        if (rx_done && is_cmd(rx_data)) begin
          cmd_wr_d = (rx_data == CMD_WRITE);
          to_d     = TO_RELOAD;
          state_d  = ADDR_H;
        end
      end
      ADDR_H: begin
        if (rx_done) begin
          // Address bits [15:14] are dropped here.
          addr_d[CSR_AW-1:BYTE_W] = rx_data[CSR_AW-BYTE_W-1:0];
          to_d    = TO_RELOAD;
          state_d = ADDR_L;
        end else if (to_q == '0) begin
          state_d = IDLE;
        end else begin
          to_d = to_q - TIMEOUT_W'(1);
        end
      end
      ADDR_L: begin
        if (rx_done) begin
          addr_d[BYTE_W-1:0] = rx_data;
          to_d = TO_RELOAD;
          if (cmd_wr_q) begin
            wcnt_d  = '0;
            state_d = WDATA;
          end else begin
            state_d = RADDR;
          end
        end else if (to_q == '0) begin
          state_d = IDLE;
        end else begin
          to_d = to_q - TIMEOUT_W'(1);
        end
      end
      WDATA: begin
        if (rx_done) begin
          req_d.wdata = {req_q.wdata[CSR_DW-BYTE_W-1:0], rx_data};
          wcnt_d      = wcnt_q + 2'd1;
          to_d        = TO_RELOAD;
          if (wcnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end else if (to_q == '0) begin
          state_d = IDLE;
        end else begin
          to_d = to_q - TIMEOUT_W'(1);
        end
      end
      WRITE: begin
`ifdef UART_CSR_MASTER_WRACK_EN
        ser_load_c   = 1'b1;
        ser_word_c   = {ACK_BYTE, (CSR_DW-BYTE_W)'(0)};
        ser_nbytes_c = NBYTES_W'(1);
        state_d      = TXSEND;
`else
        state_d = IDLE;
`endif
      end
      RADDR: begin
        state_d = RSAMPLE;
      end
      RSAMPLE: begin
        ser_load_c   = 1'b1;
        ser_word_c   = csr_di;
        ser_nbytes_c = NBYTES_W'(4);
        state_d      = TXSEND;
      end
      TXSEND: begin
        state_d = TXWAIT;
      end
      TXWAIT: begin
        if (ser_done_c) begin
          state_d = IDLE;
        end else if (tx_done) begin
          state_d = TXSEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus outputs follow the next state so they line up with WRITE/RADDR.
    req_d.we   = (state_d == WRITE);
    req_d.addr = ((state_d == WRITE) || (state_d == RADDR)) ? addr_d : '0;
    busy_d     = (state_d != IDLE);
  end

  // Byte serializer for read-back data and the optional write ACK.
  uart_csr_tx_serializer u_tx_ser (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .load_i    (ser_load_c),
    .word_i    (ser_word_c),
    .nbytes_i  (ser_nbytes_c),
    .tx_done_i (tx_done),
    .tx_data_o (tx_data),
    .tx_wr_o   (tx_wr),
    .done_c_o  (ser_done_c)
  );

  assign csr_a  = req_q.addr;
  assign csr_we = req_q.we;
  assign csr_do = req_q.wdata;
  assign busy   = busy_q;

endmodule
